cache_bus_bridge: RTL

- Sits directly downstream of the L1 cache's memory port.
- Turns the cache's single-cycle mem_req pulse into system-bus transactions:
  - a read becomes a line-fill burst of BEATS x 64-bit beats, assembled into one BLOCKSZ line;
  - a write becomes a single-word write (address beat, then data beat).
- Returns a one-cycle mem_data_valid when the fill or the write completes.

---
 rtl/cache_bus_bridge.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_bus_bridge.sv
// ============================================================================
//  Module   : cache_bus_bridge
//  Brief    : Converts single-cycle L1 cache memory requests into system-bus
//             transactions: line-fill read bursts and single-word writes.
//  Options  : CACHE_BUS_TIMEOUT_EN - adds a response watchdog that forces
//             completion with mem_err after TIMEOUT_CYCLES idle bus cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_bus_bridge #(
    parameter int BLOCKSZ        = 512,
    parameter int WIDTH          = 64,
    parameter int ADDRESSSIZE    = 64,
    parameter int OFFWIDTH       = 6,
    parameter int BEATS          = 8,
    parameter int TAGWIDTH       = 13,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_req,
    input  logic [ADDRESSSIZE-1:0] mem_address,
    input  logic                   mem_wr_en,
    input  logic [WIDTH-1:0]       mem_data_out,
    output logic [BLOCKSZ-1:0]     mem_data_in,
    output logic                   mem_data_valid,
    output logic                   mem_err,
    output logic                   busy,
    output logic                   bus_reqcyc,
    output logic [TAGWIDTH-1:0]    bus_reqtag,
    output logic [WIDTH-1:0]       bus_req,
    input  logic                   bus_reqack,
    input  logic                   bus_respcyc,
    input  logic [WIDTH-1:0]       bus_resp,
    output logic                   bus_respack
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Address masks: line-aligned for fills, 8-byte aligned for word writes
    localparam logic [ADDRESSSIZE-1:0] c_line_mask = {{(ADDRESSSIZE-OFFWIDTH){1'b1}}, {OFFWIDTH{1'b0}}};
    localparam logic [ADDRESSSIZE-1:0] c_word_mask = {{(ADDRESSSIZE-3){1'b1}}, 3'b000};
    localparam logic [TAGWIDTH-1:0]    c_tag_write = {1'b1, {(TAGWIDTH-1){1'b0}}};

    // Elaboration-time sanity checks on the configuration
    if (BEATS * WIDTH != BLOCKSZ) begin : g_chk_beats
        $error("cache_bus_bridge: BEATS*WIDTH must equal BLOCKSZ");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("cache_bus_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          beat_q,  beat_d;
    logic [ADDRESSSIZE-1:0] addr_q,  addr_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [BLOCKSZ-1:0]     line_q,  line_d;

`ifdef CACHE_BUS_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic           w_active;
    logic           w_progress;

    // Watchdog is fed by any bus-side progress: a request ack or a response beat
    assign w_active   = (state_q == S_RD_REQ) || (state_q == S_RD_RESP) ||
                        (state_q == S_WR_ADDR) || (state_q == S_WR_DATA);
    assign w_progress = (((state_q == S_RD_REQ) || (state_q == S_WR_ADDR) ||
                          (state_q == S_WR_DATA)) && bus_reqack) ||
                        ((state_q == S_RD_RESP) && bus_respcyc);
`endif

    // Next-state, datapath updates and bus-side outputs
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        line_d         = line_q;
        bus_reqcyc     = 1'b0;
        bus_reqtag     = '0;
        bus_req        = '0;
        bus_respack    = 1'b0;
        mem_data_valid = 1'b0;
        busy           = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_address;
                    wdata_d = mem_data_out;
                    state_d = mem_wr_en ? S_WR_ADDR : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = WIDTH'(addr_q & c_line_mask);
                if (bus_reqack) begin
                    beat_d  = '0;
                    state_d = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    line_d[beat_q*WIDTH +: WIDTH] = bus_resp;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == CW'(BEATS-1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WR_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_reqtag = c_tag_write;
                bus_req    = WIDTH'(addr_q & c_word_mask);
                if (bus_reqack) begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                bus_reqcyc = 1'b1;
                bus_reqtag = c_tag_write;
                bus_req    = wdata_q;
                if (bus_reqack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                mem_data_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef CACHE_BUS_TIMEOUT_EN
        // A stalled bus forces completion; partial fill data is kept
        wd_d  = '0;
        err_d = err_q;
        if (state_q == S_IDLE) begin
            err_d = 1'b0;
        end
        if (w_active && !w_progress) begin
            if (wd_q == WDW'(TIMEOUT_CYCLES-1)) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // State and datapath registers; reset discards any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
        end
    end

`ifdef CACHE_BUS_TIMEOUT_EN
    // Watchdog counter and timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign mem_err = (state_q == S_DONE) && err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_data_in = line_q;

endmodule

`default_nettype wire
